// File: rtl/fwd_rtype_pipeline.sv
// Three-register R-type integer pipeline (IF/ID -> ID/EX -> EX/WB) with a
// register file written from EX/WB, EX-stage forwarding from EX/WB and an
// ID-stage write-through bypass. Hazards therefore never need a stall.
module fwd_rtype_pipeline #(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic              stall,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              illegal
);

  localparam int         AW     = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
  localparam logic [5:0] DEPTH6 = 6'(RF_DEPTH);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  // IF/ID
  logic              ifid_valid_q;
  logic [31:0]       ifid_instr_q;
  // ID/EX
  logic              idex_valid_q;
  alu_op_e           idex_op_q;
  logic [4:0]        idex_rs_q, idex_rt_q, idex_rd_q, idex_shamt_q;
  logic [DATA_W-1:0] idex_a_q, idex_b_q;
  // EX/WB
  logic              wb_valid_q;
  logic [4:0]        wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  // Architectural state
  logic [DATA_W-1:0] rf_q [RF_DEPTH];
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic              illegal_q, illegal_d;

  logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
  logic              id_legal;
  alu_op_e           id_op;
  logic [DATA_W-1:0] id_a, id_b;
  logic              rf_we;
  logic [DATA_W-1:0] ex_a, ex_b, ex_res;

  assign id_rs    = ifid_instr_q[25:21];
  assign id_rt    = ifid_instr_q[20:16];
  assign id_rd    = ifid_instr_q[15:11];
  assign id_shamt = ifid_instr_q[10:6];
  assign rf_we    = wb_valid_q && !stall && (wb_addr_q != 5'd0);

  // Decode: legality check and ALU operation select
  always_comb begin
    id_legal = 1'b0;
    id_op    = ALU_ADD;
    if (ifid_instr_q[31:26] == 6'd0) begin
      case (ifid_instr_q[5:0])
        6'h20: begin id_legal = 1'b1; id_op = ALU_ADD; end
        6'h22: begin id_legal = 1'b1; id_op = ALU_SUB; end
        6'h24: begin id_legal = 1'b1; id_op = ALU_AND; end
        6'h25: begin id_legal = 1'b1; id_op = ALU_OR;  end
        6'h26: begin id_legal = 1'b1; id_op = ALU_XOR; end
        6'h27: begin id_legal = 1'b1; id_op = ALU_NOR; end
        6'h2A: begin id_legal = 1'b1; id_op = ALU_SLT; end
        6'h00: begin id_legal = 1'b1; id_op = ALU_SLL; end
        6'h02: begin id_legal = 1'b1; id_op = ALU_SRL; end
        6'h03: begin id_legal = 1'b1; id_op = ALU_SRA; end
        default: ;
      endcase
    end
    if ({1'b0, id_rs} >= DEPTH6 || {1'b0, id_rt} >= DEPTH6 || {1'b0, id_rd} >= DEPTH6)
      id_legal = 1'b0;
  end

  // ID register read with write-through bypass of the same-edge RF write
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs != 5'd0) id_a = rf_q[id_rs[AW-1:0]];
    if (id_rt != 5'd0) id_b = rf_q[id_rt[AW-1:0]];
    if (rf_we && wb_addr_q == id_rs) id_a = wb_data_q;
    if (rf_we && wb_addr_q == id_rt) id_b = wb_data_q;
  end

  // EX operand forwarding from EX/WB, then the ALU
  always_comb begin
    ex_a = idex_a_q;
    ex_b = idex_b_q;
    if (wb_valid_q && wb_addr_q != 5'd0 && wb_addr_q == idex_rs_q) ex_a = wb_data_q;
    if (wb_valid_q && wb_addr_q != 5'd0 && wb_addr_q == idex_rt_q) ex_b = wb_data_q;
    // Shift amounts at or beyond DATA_W yield 0 (sll/srl) or sign fill (sra)
    // directly from the language's shift semantics.
    case (idex_op_q)
      ALU_ADD: ex_res = ex_a + ex_b;
      ALU_SUB: ex_res = ex_a - ex_b;
      ALU_AND: ex_res = ex_a & ex_b;
      ALU_OR:  ex_res = ex_a | ex_b;
      ALU_XOR: ex_res = ex_a ^ ex_b;
      ALU_NOR: ex_res = ~(ex_a | ex_b);
      ALU_SLT: ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      ALU_SLL: ex_res = ex_b << idex_shamt_q;
      ALU_SRL: ex_res = ex_b >> idex_shamt_q;
      ALU_SRA: ex_res = $signed(ex_b) >>> idex_shamt_q;
      default: ex_res = '0;
    endcase
  end

  // Retire counter and sticky illegal flag next state
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    illegal_d    = illegal_q;
    if (!stall) begin
      if (wb_valid_q) retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (ifid_valid_q && !id_legal) illegal_d = 1'b1;
    end
  end

  // Pipeline registers; everything freezes while stall is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      idex_valid_q <= 1'b0;
      idex_op_q    <= ALU_ADD;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      idex_shamt_q <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      retire_cnt_q <= '0;
      illegal_q    <= 1'b0;
    end else if (!stall) begin
      ifid_valid_q <= instr_valid;
      ifid_instr_q <= instr;
      idex_valid_q <= ifid_valid_q && id_legal;
      idex_op_q    <= id_op;
      idex_rs_q    <= id_rs;
      idex_rt_q    <= id_rt;
      idex_rd_q    <= id_rd;
      idex_shamt_q <= id_shamt;
      idex_a_q     <= id_a;
      idex_b_q     <= id_b;
      wb_valid_q   <= idex_valid_q;
      wb_addr_q    <= idex_rd_q;
      wb_data_q    <= ex_res;
      retire_cnt_q <= retire_cnt_d;
      illegal_q    <= illegal_d;
    end
  end

  // Register file write from EX/WB; r0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[wb_addr_q[AW-1:0]] <= wb_data_q;
    end
  end

  // Debug read port: r0 and out-of-range addresses read as zero
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != 5'd0 && {1'b0, dbg_addr} < DEPTH6) dbg_data = rf_q[dbg_addr[AW-1:0]];
  end

  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign retire_cnt = retire_cnt_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_fwd_rtype_pipeline.sv
// Bench for fwd_rtype_pipeline: two instances (A: 32-bit data, 16 registers,
// 4-bit counter; B: 8-bit data, 32 registers, 16-bit counter) share one
// instruction stream. A program-order reference model computes every result
// at issue time and delays it three accepted edges to predict write-back.
module tb_fwd_rtype_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, stall;
  logic [31:0] instr;
  logic [4:0]  dbg_addr;

  logic [31:0] dbg_a, wbd_a;
  logic        wbv_a, ill_a;
  logic [4:0]  wba_a;
  logic [3:0]  rc_a;
  logic [7:0]  dbg_b, wbd_b;
  logic        wbv_b, ill_b;
  logic [4:0]  wba_b;
  logic [15:0] rc_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_rtype_pipeline #(.DATA_W(32), .RF_DEPTH(16), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .stall(stall),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a), .wb_valid(wbv_a), .wb_addr(wba_a),
    .wb_data(wbd_a), .retire_cnt(rc_a), .illegal(ill_a));

  fwd_rtype_pipeline #(.DATA_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .stall(stall),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wb_valid(wbv_b), .wb_addr(wba_b),
    .wb_data(wbd_b), .retire_cnt(rc_b), .illegal(ill_b));

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLL = 6'h00,
                         F_SRL = 6'h02, F_SRA = 6'h03;

  // ---------------- reference model ----------------
  typedef struct { bit v; bit ill; logic [4:0] rd; logic [63:0] d; } slot_t;
  logic [63:0] arch [2][32];   // program-order state (includes in-flight results)
  logic [63:0] comm [2][32];   // state visible on the debug port
  slot_t       pipe [2][3];    // [2] is what write-back shows
  int unsigned mcnt [2];
  bit          mill [2];

  function automatic int wid(int p);   return (p == 0) ? 32 : 8;  endfunction
  function automatic int depth(int p); return (p == 0) ? 16 : 32; endfunction

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 1'b0; s.ill = 1'b0; s.rd = '0; s.d = '0;
    return s;
  endfunction

  function automatic logic [63:0] sext(logic [63:0] x, int w);
    logic [63:0] t;
    t = x << (64 - w);
    return 64'($signed(t) >>> (64 - w));
  endfunction

  function automatic bit legal(int p, logic [31:0] ins);
    if (ins[31:26] != 6'd0) return 1'b0;
    if (!(ins[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLL, F_SRL, F_SRA}))
      return 1'b0;
    if (int'(ins[25:21]) >= depth(p) || int'(ins[20:16]) >= depth(p) || int'(ins[15:11]) >= depth(p))
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] compute(int p, logic [31:0] ins);
    logic [63:0] a, b, r, m;
    int sh, w;
    w  = wid(p);
    m  = (64'd1 << w) - 64'd1;
    a  = arch[p][ins[25:21]];
    b  = arch[p][ins[20:16]];
    sh = int'(ins[10:6]);
    case (ins[5:0])
      F_ADD:   r = a + b;
      F_SUB:   r = a - b;
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_XOR:   r = a ^ b;
      F_NOR:   r = ~(a | b);
      F_SLT:   r = ($signed(sext(a, w)) < $signed(sext(b, w))) ? 64'd1 : 64'd0;
      F_SLL:   r = b << sh;
      F_SRL:   r = b >> sh;
      F_SRA:   r = 64'($signed(sext(b, w)) >>> sh);
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 32; r++) begin arch[p][r] = '0; comm[p][r] = '0; end
      for (int s = 0; s < 3; s++) pipe[p][s] = empty_slot();
      mcnt[p] = 0;
      mill[p] = 1'b0;
    end
  endtask

  task automatic model_edge(bit v, logic [31:0] ins, bit st);
    if (st) return;
    for (int p = 0; p < 2; p++) begin
      if (pipe[p][2].v) begin
        mcnt[p]++;
        if (pipe[p][2].rd != 5'd0) comm[p][pipe[p][2].rd] = pipe[p][2].d;
      end
      if (pipe[p][0].ill) mill[p] = 1'b1;
      pipe[p][2] = pipe[p][1];
      pipe[p][1] = pipe[p][0];
      pipe[p][0] = empty_slot();
      if (v) begin
        if (legal(p, ins)) begin
          pipe[p][0].v  = 1'b1;
          pipe[p][0].rd = ins[15:11];
          pipe[p][0].d  = compute(p, ins);
          if (ins[15:11] != 5'd0) arch[p][ins[15:11]] = pipe[p][0].d;
        end else begin
          pipe[p][0].ill = 1'b1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      logic [63:0] v, a, d, rc, il, dg, edbg, emask;
      string n;
      n = (p == 0) ? "A" : "B";
      if (p == 0) begin
        v = 64'(wbv_a); a = 64'(wba_a); d = 64'(wbd_a); rc = 64'(rc_a); il = 64'(ill_a); dg = 64'(dbg_a);
        emask = 64'hF;
      end else begin
        v = 64'(wbv_b); a = 64'(wba_b); d = 64'(wbd_b); rc = 64'(rc_b); il = 64'(ill_b); dg = 64'(dbg_b);
        emask = 64'hFFFF;
      end
      check($sformatf("%s_wb_valid", n), v, 64'(pipe[p][2].v));
      if (pipe[p][2].v) begin
        check($sformatf("%s_wb_addr", n), a, 64'(pipe[p][2].rd));
        check($sformatf("%s_wb_data", n), d, pipe[p][2].d);
      end
      check($sformatf("%s_retire_cnt", n), rc, 64'(mcnt[p]) & emask);
      check($sformatf("%s_illegal", n), il, 64'(mill[p]));
      if (dbg_addr == 5'd0 || int'(dbg_addr) >= depth(p)) edbg = 64'd0;
      else edbg = comm[p][dbg_addr];
      check($sformatf("%s_dbg_data[%0d]", n, dbg_addr), dg, edbg);
    end
  endtask

  // Drive at the falling edge, model the rising edge, check at the next falling edge
  task automatic cycle(bit v, logic [31:0] ins, bit st);
    instr_valid = v;
    instr       = ins;
    stall       = st;
    dbg_addr    = 5'($urandom_range(0, 31));
    @(posedge clk);
    model_edge(v, ins, st);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset between edges while instructions are in flight;
  // the instruction presented now must be taken by the first edge afterwards.
  task automatic pulse_reset(logic [31:0] first_ins);
    instr_valid = 1'b1;
    instr       = first_ins;
    stall       = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_A_wb_valid", 64'(wbv_a), 64'd0);
    check("rst_A_wb_addr", 64'(wba_a), 64'd0);
    check("rst_A_wb_data", 64'(wbd_a), 64'd0);
    check("rst_A_retire_cnt", 64'(rc_a), 64'd0);
    check("rst_B_illegal", 64'(ill_b), 64'd0);
    check("rst_B_wb_data", 64'(wbd_b), 64'd0);
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b1, first_ins, 1'b0);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] R(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [5:0] fsel(int k);
    case (k)
      0: return F_ADD; 1: return F_SUB; 2: return F_AND; 3: return F_OR; 4: return F_XOR;
      5: return F_NOR; 6: return F_SLT; 7: return F_SLL; 8: return F_SRL; default: return F_SRA;
    endcase
  endfunction

  function automatic logic [31:0] rnd_ins(bit bad_ok);
    int k, hi;
    logic [31:0] ins;
    k  = int'($urandom_range(0, 9));
    hi = (k < 5) ? 7 : ((k < 9 || !bad_ok) ? 15 : 31);
    ins = R(int'($urandom_range(0, hi)), int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
            int'($urandom_range(0, 31)), fsel(int'($urandom_range(0, 9))));
    if (bad_ok && $urandom_range(0, 19) == 0) ins[31:26] = 6'($urandom_range(1, 63));
    if (bad_ok && $urandom_range(0, 19) == 0) ins[5:0] = 6'($urandom);
    return ins;
  endfunction

  // ---------------- directed table (expectations for instance A) ----------------
  typedef struct { bit v; logic [31:0] ins; bit ev; logic [4:0] ea; logic [31:0] ed; } vec_t;
  vec_t vec [24];
  int   nv;

  // Result of the row being added shows on write-back two table rows later
  task automatic row(bit v, logic [31:0] ins, int ea, logic [31:0] ed);
    vec[nv].v   = v;
    vec[nv].ins = ins;
    if (v) begin
      vec[nv+2].ev = 1'b1;
      vec[nv+2].ea = 5'(ea);
      vec[nv+2].ed = ed;
    end
    nv++;
  endtask

  initial begin
    logic       sv_v [9];
    logic [31:0] sv_d [9];

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; stall = 1'b0; dbg_addr = '0;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      vec[i].v = 1'b0; vec[i].ins = '0; vec[i].ev = 1'b0; vec[i].ea = '0; vec[i].ed = '0;
    end
    nv = 0;
    row(1, R(0, 0, 1, 0, F_NOR),   1, 32'hFFFF_FFFF);
    row(1, R(0, 1, 2, 0, F_SUB),   2, 32'h0000_0001);
    row(1, R(0, 2, 3, 2, F_SLL),   3, 32'h0000_0004);
    row(1, R(3, 2, 1, 0, F_ADD),   1, 32'h0000_0005);
    row(1, R(2, 2, 4, 0, F_ADD),   4, 32'h0000_0002);
    row(1, R(4, 2, 2, 0, F_ADD),   2, 32'h0000_0003);
    row(1, R(1, 2, 3, 0, F_ADD),   3, 32'h0000_0008);
    row(1, R(1, 2, 4, 0, F_ADD),   4, 32'h0000_0008);
    row(1, R(4, 1, 5, 0, F_SUB),   5, 32'h0000_0003);
    row(1, R(4, 0, 6, 0, F_OR),    6, 32'h0000_0008);
    row(1, R(0, 0, 8, 0, F_NOR),   8, 32'hFFFF_FFFF);
    row(1, R(0, 8, 9, 31, F_SRL),  9, 32'h0000_0001);
    row(1, R(0, 9, 10, 31, F_SLL), 10, 32'h8000_0000);
    row(1, R(0, 10, 7, 4, F_SRA),  7, 32'hF800_0000);
    row(1, R(8, 9, 11, 0, F_SLT),  11, 32'h0000_0001);
    row(1, R(0, 8, 12, 1, F_SRL),  12, 32'h7FFF_FFFF);
    row(1, R(12, 9, 13, 0, F_ADD), 13, 32'h8000_0000);
    row(1, R(1, 2, 0, 0, F_ADD),   0, 32'h0000_0008);
    row(0, '0, 0, '0);
    row(1, R(0, 0, 14, 0, F_OR),   14, 32'h0000_0000);
    row(1, R(9, 8, 15, 0, F_SLT),  15, 32'h0000_0000);
    row(0, '0, 0, '0);
    row(0, '0, 0, '0);

    // Reset state
    #2;
    check("init_A_wb_addr", 64'(wba_a), 64'd0);
    check("init_A_wb_data", 64'(wbd_a), 64'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < nv; i++) begin
      cycle(vec[i].v, vec[i].ins, 1'b0);
      check($sformatf("tbl%0d_wb_valid", i), 64'(wbv_a), 64'(vec[i].ev));
      if (vec[i].ev) begin
        check($sformatf("tbl%0d_wb_addr", i), 64'(wba_a), 64'(vec[i].ea));
        check($sformatf("tbl%0d_wb_data", i), 64'(wbd_a), 64'(vec[i].ed));
      end
    end
    check("tbl_A_illegal", 64'(ill_a), 64'd0);

    // Illegal instructions: bad opcode, bad funct, rd beyond A's register file
    cycle(1, {6'h08, 5'd1, 5'd2, 5'd3, 5'd0, F_ADD}, 1'b0);
    check("ill_A_wb_valid0", 64'(wbv_a), 64'd0);
    check("ill_A_flag_early", 64'(ill_a), 64'd0);
    cycle(1, R(1, 2, 3, 0, 6'h18), 1'b0);
    check("ill_A_wb_valid1", 64'(wbv_a), 64'd0);
    check("ill_A_flag_set", 64'(ill_a), 64'd1);
    cycle(1, R(1, 2, 20, 0, F_ADD), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 1'b0);
      check($sformatf("ill_A_wb_valid_drain%0d", i), 64'(wbv_a), 64'd0);
    end
    check("ill_A_flag_sticky", 64'(ill_a), 64'd1);
    check("ill_A_retire_cnt", 64'(rc_a), 64'd4);

    // Stall for three cycles with three instructions in flight (r1=5, r2=3)
    sv_v = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    sv_d = '{0, 0, 8, 8, 8, 8, 2, 6, 0};
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: cycle(1, R(1, 2, 3, 0, F_ADD), 1'b0);
        1: cycle(1, R(1, 2, 4, 0, F_SUB), 1'b0);
        2: cycle(1, R(1, 2, 5, 0, F_XOR), 1'b0);
        3, 4, 5: cycle(1, R(0, 0, 1, 0, F_ADD), 1'b1);
        default: cycle(0, '0, 1'b0);
      endcase
      check($sformatf("stall%0d_wb_valid", i), 64'(wbv_a), 64'(sv_v[i]));
      if (sv_v[i]) check($sformatf("stall%0d_wb_data", i), 64'(wbd_a), 64'(sv_d[i]));
    end

    // Reset with two in flight, then 17 retires wrap A's 4-bit counter to 1
    cycle(1, R(1, 2, 6, 0, F_ADD), 1'b0);
    cycle(1, R(1, 2, 7, 0, F_ADD), 1'b0);
    pulse_reset(R(0, 0, 1, 0, F_NOR));
    for (int i = 0; i < 16; i++) cycle(1, rnd_ins(1'b0), 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1'b0);
    check("wrap_A_retire_cnt", 64'(rc_a), 64'd1);
    check("wrap_B_retire_cnt", 64'(rc_b), 64'd17);

    // Randomized traffic with stalls, bubbles and occasional illegal instructions
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) pulse_reset(rnd_ins(1'b1));
      else cycle($urandom_range(0, 9) < 8, rnd_ins(1'b1), $urandom_range(0, 9) < 2);
    end
    for (int i = 0; i < 4; i++) cycle(0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
